// File: rtl/life_grid_engine_if.sv
// Controller-to-engine bundle: level mode requests in, board and status out.
// The master drives the mode levels; the slave (engine) drives the board view.
interface life_grid_engine_if #(
   parameter int unsigned GEN_W = 16
);
   logic             rst;
   logic             rnd;
   logic             strt;
   logic [63:0]      grid;
   logic [GEN_W-1:0] gen_count;
   logic             gen_tick;
   logic             stable;

   modport master (
      output rst, rnd, strt,
      input  grid, gen_count, gen_tick, stable
   );

   modport slave (
      input  rst, rnd, strt,
      output grid, gen_count, gen_tick, stable
   );
endinterface

// File: rtl/life_grid_engine.sv
// 8x8 toroidal Game of Life engine: seed load, LFSR random capture and timed stepping.
// Mode priority is rst > rnd > strt; with no mode requested everything but the LFSR holds.
module life_grid_engine #(
   parameter logic [63:0] DEFAULT_SEED = 64'h0412_6424_0034_3C28,
   parameter logic [63:0] LFSR_INIT    = 64'hACE1_ACE1_ACE1_ACE1,
   parameter int unsigned TICK_DIV     = 25_000_000,
   parameter int unsigned GEN_W        = 16
) (
   input logic               clk,
   input logic               reset_n,
   life_grid_engine_if.slave bus
);
   localparam int unsigned  TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [63:0]      r_grid;
   logic [63:0]      r_lfsr;
   logic [TW-1:0]    r_tick;
   logic [GEN_W-1:0] r_gen_count;
   logic             r_gen_tick;
   logic             r_stable;

   logic [63:0]      w_next;
   logic             w_lfsr_fb;

   assign w_lfsr_fb = r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59];

   // Neighbour rows/cols are formed in 3 bits so the wrap modulo 8 is free.
   always_comb begin : p_next
      logic [3:0] cnt;
      logic [2:0] nrow;
      logic [2:0] ncol;
      w_next = '0;
      cnt    = '0;
      nrow   = '0;
      ncol   = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = '0;
            for (int dr = 0; dr < 3; dr++) begin
               for (int dc = 0; dc < 3; dc++) begin
                  if (!(dr == 1 && dc == 1)) begin
                     nrow = 3'(r + dr + 7);
                     ncol = 3'(c + dc + 7);
                     cnt  = cnt + {3'b000, r_grid[{nrow, ncol}]};
                  end
               end
            end
            w_next[{3'(r), 3'(c)}] = (cnt == 4'd3) |
                                     (r_grid[{3'(r), 3'(c)}] & (cnt == 4'd2));
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_grid      <= DEFAULT_SEED;
         r_lfsr      <= LFSR_INIT;
         r_tick      <= '0;
         r_gen_count <= '0;
         r_gen_tick  <= 1'b0;
         r_stable    <= 1'b0;
      end else begin
         // A zero LFSR would lock up, so it is reseeded.
         r_lfsr <= (r_lfsr == '0) ? LFSR_INIT : {r_lfsr[62:0], w_lfsr_fb};
         if (bus.rst) begin
            r_grid      <= DEFAULT_SEED;
            r_tick      <= '0;
            r_gen_count <= '0;
            r_gen_tick  <= 1'b0;
            r_stable    <= 1'b0;
         end else if (bus.rnd) begin
            r_grid      <= r_lfsr;
            r_tick      <= '0;
            r_gen_count <= '0;
            r_gen_tick  <= 1'b0;
            r_stable    <= 1'b0;
         end else if (bus.strt) begin
            r_stable <= (w_next == r_grid);
            if (r_tick == TICK_LAST) begin
               r_tick      <= '0;
               r_grid      <= w_next;
               r_gen_count <= r_gen_count + GEN_W'(1);
               r_gen_tick  <= 1'b1;
            end else begin
               r_tick     <= r_tick + TW'(1);
               r_gen_tick <= 1'b0;
            end
         end
      end
   end

   assign bus.grid      = r_grid;
   assign bus.gen_count = r_gen_count;
   assign bus.gen_tick  = r_gen_tick;
   assign bus.stable    = r_stable;
endmodule
